// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider with a registered divided clock,
// a per-period tick, and ratio/enable changes applied only at period boundaries.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a falling-edge flop giving 50% duty on odd ratios.
module clk_div_prog #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en_in,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load_in,
    output logic             clk_out,
    output logic             tick_out,
    output logic             pending_out,
    output logic             err_out,
    output logic             running_out
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             run_q, run_d;

    logic             wrap;
    logic             load_ok;
    logic             load_bad;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] hi_len;

    assign wrap     = (state_q != ST_IDLE) && (cnt_q == (div_q - DIV_W'(1)));
    assign load_ok  = div_load_in && (div_in >= DIV_MIN);
    assign load_bad = div_load_in && (div_in < DIV_MIN);
    assign cnt_inc  = wrap ? '0 : (cnt_q + DIV_W'(1));

    // Number of leading high cycles of the rising-edge flop within one period.
`ifdef CLK_DIV_ODD_DUTY50_EN
    assign hi_len = div_q >> 1;
`else
    assign hi_len = (div_q >> 1) + DIV_W'(div_q[0]);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_d      = 1'b0;
        tick_d     = 1'b0;
        err_d      = load_bad;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // IDLE is itself a boundary: a value left pending by the last wrap commits here.
                if (pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
                if (load_ok) begin
                    div_d      = div_in;
                    pend_vld_d = 1'b0;
                end
                if (en_in) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            default: begin
                cnt_d = cnt_inc;
                if (wrap && pend_vld_q) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                end
                if (load_ok) begin
                    pend_d     = div_in;
                    pend_vld_d = 1'b1;
                end
                if (!en_in && wrap) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = en_in ? ST_RUN : ST_DRAIN;
                    clk_d   = (cnt_inc < hi_len);
                    tick_d  = wrap;
                end
            end
        endcase

        run_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            run_q      <= run_d;
        end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    // Half-cycle extension of the high phase for odd ratios only.
    logic q_neg_q;

    always_ff @(negedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= clk_q & div_q[0];
        end
    end

    assign clk_out = clk_q | q_neg_q;
`else
    assign clk_out = clk_q;
`endif

    assign tick_out    = tick_q;
    assign pending_out = pend_vld_q;
    assign err_out     = err_q;
    assign running_out = run_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: directed vector table, reset/corner sequences,
// randomized traffic against a period-position reference model, and a duty-cycle measurement.
module tb_clk_div_prog;

    localparam int unsigned DIV_W = 8;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             en_in;
    logic [DIV_W-1:0] div_in;
    logic             div_load_in;
    logic             clk_out;
    logic             tick_out;
    logic             pending_out;
    logic             err_out;
    logic             running_out;

    clk_div_prog #(
        .DIV_W      (DIV_W),
        .DIV_DEFAULT(4)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .en_in      (en_in),
        .div_in     (div_in),
        .div_load_in(div_load_in),
        .clk_out    (clk_out),
        .tick_out   (tick_out),
        .pending_out(pending_out),
        .err_out    (err_out),
        .running_out(running_out)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        bit       en;
        bit       ld;
        int       dv;
        bit [4:0] exp;   // {clk, tick, pending, err, running}
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: position inside the current output period plus ratio bookkeeping.
    int m_n;
    int m_pos;
    int m_pend;      // -1 when nothing is waiting
    bit m_run;       // RUN or DRAIN
    bit m_err;

    function automatic void model_reset();
        m_n    = 4;
        m_pos  = 0;
        m_pend = -1;
        m_run  = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(bit en, bit ld, int dv);
        bit ok;
        bit boundary;
        m_err = ld && (dv < 2);
        ok    = ld && (dv >= 2);
        if (!m_run) begin
            if (m_pend >= 0) begin
                m_n    = m_pend;
                m_pend = -1;
            end
            if (ok) m_n = dv;
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else begin
            boundary = (m_pos == m_n - 1);
            if (boundary && m_pend >= 0) begin
                m_n    = m_pend;
                m_pend = -1;
            end
            if (ok) m_pend = dv;
            m_pos = boundary ? 0 : m_pos + 1;
            if (boundary && !en) m_run = 1'b0;
        end
    endfunction

    function automatic bit [4:0] model_out();
        bit c, t;
        c = m_run && (m_pos < (m_n + 1) / 2);
        t = m_run && (m_pos == 0);
        return {c, t, (m_pend >= 0), m_err, m_run};
    endfunction

    function automatic bit [4:0] dut_out();
        return {clk_out, tick_out, pending_out, err_out, running_out};
    endfunction

    task automatic check(input string name, input bit [4:0] act, input bit [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {clk,tick,pend,err,run}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present inputs, let one rising edge sample them, then settle past the edge.
    task automatic drive(input bit en, input bit ld, input int dv);
        en_in       = en;
        div_load_in = ld;
        div_in      = DIV_W'(dv);
        @(posedge clk_in);
        model_step(en, ld, dv);
        #1;
    endtask

    task automatic do_reset();
        en_in       = 1'b0;
        div_load_in = 1'b0;
        div_in      = '0;
        rst_n_in    = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    function automatic void add(input bit en, input bit ld, input int dv, input bit [4:0] exp);
        vec_t v;
        v.en  = en;
        v.ld  = ld;
        v.dv  = dv;
        v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        int  budget;
        bit  en_r;
        longint t_rise, t_fall, t_rise2;
        logic prev;

        // Default N=4, then load 6 mid-period, reject 1, load 5, drain, re-enable, idle load 3.
        add(0,0,0,5'b00000);
        add(1,0,0,5'b11001); add(1,0,0,5'b10001); add(1,0,0,5'b00001); add(1,0,0,5'b00001);
        add(1,0,0,5'b11001); add(1,0,0,5'b10001);
        add(1,1,6,5'b00101); add(1,0,0,5'b00101);
        add(1,0,0,5'b11001); add(1,0,0,5'b10001); add(1,0,0,5'b10001);
        add(1,0,0,5'b00001); add(1,0,0,5'b00001); add(1,0,0,5'b00001);
        add(1,0,0,5'b11001);
        add(1,1,1,5'b10011); add(1,0,0,5'b10001);
        add(1,0,0,5'b00001); add(1,0,0,5'b00001); add(1,0,0,5'b00001);
        add(1,0,0,5'b11001);
        add(1,1,5,5'b10101); add(1,0,0,5'b10101);
        add(1,0,0,5'b00101); add(1,0,0,5'b00101); add(1,0,0,5'b00101);
        add(1,0,0,5'b11001); add(1,0,0,5'b10001);
        add(0,0,0,5'b10001); add(0,0,0,5'b00001); add(0,0,0,5'b00001);
        add(0,0,0,5'b00000); add(0,0,0,5'b00000);
        add(1,0,0,5'b11001); add(0,0,0,5'b10001); add(1,0,0,5'b10001);
        add(1,0,0,5'b00001); add(1,0,0,5'b00001); add(1,0,0,5'b11001);
        add(0,0,0,5'b10001); add(0,0,0,5'b10001); add(0,0,0,5'b00001);
        add(0,0,0,5'b00001); add(0,0,0,5'b00000);
        add(0,1,3,5'b00000);
        add(1,0,0,5'b11001); add(1,0,0,5'b10001); add(1,0,0,5'b00001); add(1,0,0,5'b11001);

        en_in       = 1'b0;
        div_load_in = 1'b0;
        div_in      = '0;
        rst_n_in    = 1'b0;
        model_reset();
        #5;
        check("reset_state", dut_out(), 5'b00000);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ld, vecs[i].dv);
            check($sformatf("vec%0d", i), dut_out(), vecs[i].exp);
        end

        // Return to IDLE, run with N=7, then hit asynchronous reset during the high phase.
        budget = 0;
        while (running_out && budget < 300) begin
            drive(0, 0, 0);
            budget++;
        end
        check("drain_to_idle", {4'b0000, running_out}, 5'b00000);
        drive(0, 1, 7);
        drive(1, 0, 0);
        drive(1, 0, 0);
        check("n7_high_phase", dut_out(), 5'b10001);
        #3 rst_n_in = 1'b0;
        #1 check("async_reset", dut_out(), 5'b00000);
        @(posedge clk_in);
        #1 check("reset_held", dut_out(), 5'b00000);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0);
            check($sformatf("post_reset_n4_%0d", i), dut_out(),
                  {((i % 4) < 2), ((i % 4) == 0), 1'b0, 1'b0, 1'b1});
        end

        // Randomized traffic against the model.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) en_r = ~en_r;
            drive(en_r, ($urandom_range(0, 9) == 0), int'($urandom_range(0, 11)));
            check($sformatf("rand%0d", i), dut_out(), model_out());
        end

        // Duty measurement for N=5, sampled on an offset grid between clock edges.
        do_reset();
        drive(0, 1, 5);
        en_in       = 1'b1;
        div_load_in = 1'b0;
        t_rise  = -1;
        t_fall  = -1;
        t_rise2 = -1;
        prev    = clk_out;
        for (int k = 0; k < 200 && t_rise2 < 0; k++) begin
            #2;
            if (!prev && clk_out) begin
                if (t_rise < 0) t_rise = longint'($time);
                else if (t_fall >= 0) t_rise2 = longint'($time);
            end
            if (prev && !clk_out && t_rise >= 0 && t_fall < 0) t_fall = longint'($time);
            prev = clk_out;
        end
`ifdef CLK_DIV_ODD_DUTY50_EN
        check_int("n5_high_time", t_fall - t_rise, 50);
        check_int("n5_low_time", t_rise2 - t_fall, 50);
`else
        check_int("n5_high_time", t_fall - t_rise, 60);
        check_int("n5_low_time", t_rise2 - t_fall, 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
